// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
// The master side drives requests and MTHI/MTLO writes; the slave side returns status and HI/LO.
interface mult_div_unit_if #(
   parameter int NB_REG = 32,
   parameter int NB_OP  = 2
);
   logic              i_start;
   logic [NB_OP-1:0]  i_op;
   logic [NB_REG-1:0] i_a;
   logic [NB_REG-1:0] i_b;
   logic              i_hi_we;
   logic              i_lo_we;
   logic [NB_REG-1:0] i_wdata;
   logic              o_busy;
   logic              o_done;
   logic              o_div_zero;
   logic [NB_REG-1:0] o_hi;
   logic [NB_REG-1:0] o_lo;

   modport master (
      output i_start, i_op, i_a, i_b, i_hi_we, i_lo_we, i_wdata,
      input  o_busy, o_done, o_div_zero, o_hi, o_lo
   );

   modport slave (
      input  i_start, i_op, i_a, i_b, i_hi_we, i_lo_we, i_wdata,
      output o_busy, o_done, o_div_zero, o_hi, o_lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO registers; done NB_REG+1 cycles after start.
// No backpressure: o_busy stalls the pipeline, and start/MTHI/MTLO are ignored outside IDLE.
module mult_div_unit #(
   parameter int NB_REG = 32,
   parameter int NB_OP  = 2
) (
   input logic              i_clock,
   input logic              i_reset,
   mult_div_unit_if.slave   bus
);
   localparam int NB_CNT = $clog2(NB_REG);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
   state_t state, state_next;

   logic [NB_OP-1:0]    op;
   logic [NB_REG-1:0]   opnd_m;
   logic [2*NB_REG-1:0] acc, acc_step, prod_fix;
   logic [NB_CNT-1:0]   cnt;
   logic                neg_res, neg_rem, div_zero;
   logic [NB_REG-1:0]   hi, lo, res_hi, res_lo;
   logic [NB_REG-1:0]   a_abs, b_abs;
   logic [NB_REG:0]     mul_sum, rem_sh, rem_diff;
   logic                start_ok, is_div_in, is_signed_in, b_zero;

   assign start_ok     = (state == IDLE) && bus.i_start;
   assign is_div_in    = bus.i_op[1];
   assign is_signed_in = bus.i_op[0];
   assign b_zero       = (bus.i_b == '0);
   assign a_abs        = (is_signed_in && bus.i_a[NB_REG-1]) ? -bus.i_a : bus.i_a;
   assign b_abs        = (is_signed_in && bus.i_b[NB_REG-1]) ? -bus.i_b : bus.i_b;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.i_start) state_next = (is_div_in && b_zero) ? FIN : CALC;
         CALC: if (cnt == NB_CNT'(NB_REG-1)) state_next = FIN;
         FIN:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
   always_comb begin
      mul_sum  = {1'b0, acc[2*NB_REG-1:NB_REG]} + (acc[0] ? {1'b0, opnd_m} : '0);
      rem_sh   = acc[2*NB_REG-1:NB_REG-1];
      rem_diff = rem_sh - {1'b0, opnd_m};
      acc_step = {mul_sum, acc[NB_REG-1:1]};
      if (op[1]) begin
         if (rem_diff[NB_REG]) acc_step = {rem_sh[NB_REG-1:0], acc[NB_REG-2:0], 1'b0};
         else                  acc_step = {rem_diff[NB_REG-1:0], acc[NB_REG-2:0], 1'b1};
      end
   end

   always_comb begin
      prod_fix = neg_res ? -acc : acc;
      res_hi   = prod_fix[2*NB_REG-1:NB_REG];
      res_lo   = prod_fix[NB_REG-1:0];
      if (op[1]) begin
         res_lo = neg_res ? -acc[NB_REG-1:0] : acc[NB_REG-1:0];
         res_hi = neg_rem ? -acc[2*NB_REG-1:NB_REG] : acc[2*NB_REG-1:NB_REG];
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         op       <= '0;
         opnd_m   <= '0;
         acc      <= '0;
         cnt      <= '0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  op       <= bus.i_op;
                  cnt      <= '0;
                  div_zero <= is_div_in && b_zero;
                  neg_res  <= is_signed_in && !(is_div_in && b_zero)
                              && (bus.i_a[NB_REG-1] ^ bus.i_b[NB_REG-1]);
                  neg_rem  <= is_signed_in && is_div_in && !b_zero && bus.i_a[NB_REG-1];
                  if (is_div_in) begin
                     opnd_m <= b_abs;
                     // Divide-by-zero result is preloaded so FIN emits HI=a, LO=all ones.
                     acc    <= b_zero ? {bus.i_a, {NB_REG{1'b1}}} : {{NB_REG{1'b0}}, a_abs};
                  end else begin
                     opnd_m <= a_abs;
                     acc    <= {{NB_REG{1'b0}}, b_abs};
                  end
               end else begin
                  if (bus.i_hi_we) hi <= bus.i_wdata;
                  if (bus.i_lo_we) lo <= bus.i_wdata;
               end
            end
            CALC: begin
               acc <= acc_step;
               cnt <= cnt + 1'b1;
            end
            FIN: begin
               hi <= res_hi;
               lo <= res_lo;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_busy     = (state == CALC);
   assign bus.o_done     = (state == FIN);
   assign bus.o_div_zero = div_zero;
   assign bus.o_hi       = (state == FIN) ? res_hi : hi;
   assign bus.o_lo       = (state == FIN) ? res_lo : lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, signed/unsigned results, div-by-zero, ignored starts, reset abort, MTHI/MTLO.
module tb_mult_div_unit;
   localparam logic [1:0] OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11;

   logic clk = 1'b0;
   logic rst_n;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   always #5 clk = ~clk;

   mult_div_unit_if #(.NB_REG(32), .NB_OP(2)) bus ();

   mult_div_unit #(.NB_REG(32), .NB_OP(2)) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   // Issues one operation from a negedge in IDLE and returns at the negedge where o_done is seen.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int bcnt,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz);
      cyc = 0; bcnt = 0; hi = 'x; lo = 'x; dz = 1'bx;
      bus.i_op = op; bus.i_a = a; bus.i_b = b; bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         if (bus.o_busy) bcnt++;
         if (bus.o_done) begin
            cyc = n; hi = bus.o_hi; lo = bus.o_lo; dz = bus.o_div_zero;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      vec_cnt++; if (bus.o_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
      vec_cnt++; if (bus.o_done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %b want 0", bus.o_done); end
      vec_cnt++; if (bus.o_div_zero !== 1'b0) begin err_cnt++; $display("FAIL reset_dz got %b want 0", bus.o_div_zero); end
      vec_cnt++; if (bus.o_hi !== 32'h0) begin err_cnt++; $display("FAIL reset_hi got %h want 0", bus.o_hi); end
      vec_cnt++; if (bus.o_lo !== 32'h0) begin err_cnt++; $display("FAIL reset_lo got %h want 0", bus.o_lo); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_multu;
      int cyc, bcnt; logic [31:0] hi, lo; logic dz;
      do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcnt, hi, lo, dz);
      vec_cnt++; if (cyc !== 33) begin err_cnt++; $display("FAIL multu_latency got %0d want 33", cyc); end
      vec_cnt++; if (bcnt !== 32) begin err_cnt++; $display("FAIL multu_busy got %0d want 32", bcnt); end
      vec_cnt++; if (hi !== 32'hFFFF_FFFE) begin err_cnt++; $display("FAIL multu_hi got %h want fffffffe", hi); end
      vec_cnt++; if (lo !== 32'h0000_0001) begin err_cnt++; $display("FAIL multu_lo got %h want 00000001", lo); end
      @(negedge clk);
      vec_cnt++; if (bus.o_hi !== 32'hFFFF_FFFE) begin err_cnt++; $display("FAIL multu_hi_hold got %h want fffffffe", bus.o_hi); end
   endtask

   task automatic test_signed;
      int cyc, bcnt; logic [31:0] hi, lo; logic dz;
      do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, cyc, bcnt, hi, lo, dz);
      @(negedge clk);
      vec_cnt++; if (hi !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL mult_hi got %h want ffffffff", hi); end
      vec_cnt++; if (lo !== 32'hFFFF_FFEB) begin err_cnt++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
      do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc, bcnt, hi, lo, dz);
      @(negedge clk);
      vec_cnt++; if (lo !== 32'hFFFF_FFFD) begin err_cnt++; $display("FAIL div_neg_quo got %h want fffffffd", lo); end
      vec_cnt++; if (hi !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL div_neg_rem got %h want ffffffff", hi); end
      do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, cyc, bcnt, hi, lo, dz);
      @(negedge clk);
      vec_cnt++; if (lo !== 32'hFFFF_FFFD) begin err_cnt++; $display("FAIL div_negb_quo got %h want fffffffd", lo); end
      vec_cnt++; if (hi !== 32'h0000_0001) begin err_cnt++; $display("FAIL div_negb_rem got %h want 00000001", hi); end
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcnt, hi, lo, dz);
      @(negedge clk);
      vec_cnt++; if (lo !== 32'h8000_0000) begin err_cnt++; $display("FAIL div_ovf_quo got %h want 80000000", lo); end
      vec_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL div_ovf_rem got %h want 0", hi); end
      vec_cnt++; if (dz !== 1'b0) begin err_cnt++; $display("FAIL div_ovf_flag got %b want 0", dz); end
   endtask

   task automatic test_div_zero;
      int cyc, bcnt; logic [31:0] hi, lo; logic dz;
      do_op(OP_DIVU, 32'd100, 32'd0, cyc, bcnt, hi, lo, dz);
      vec_cnt++; if (cyc !== 1) begin err_cnt++; $display("FAIL dz_latency got %0d want 1", cyc); end
      vec_cnt++; if (bcnt !== 0) begin err_cnt++; $display("FAIL dz_busy got %0d want 0", bcnt); end
      vec_cnt++; if (hi !== 32'd100) begin err_cnt++; $display("FAIL dz_hi got %h want 00000064", hi); end
      vec_cnt++; if (lo !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL dz_lo got %h want ffffffff", lo); end
      vec_cnt++; if (dz !== 1'b1) begin err_cnt++; $display("FAIL dz_flag got %b want 1", dz); end
      @(negedge clk);
      vec_cnt++; if (bus.o_div_zero !== 1'b1) begin err_cnt++; $display("FAIL dz_sticky got %b want 1", bus.o_div_zero); end
      do_op(OP_DIVU, 32'd100, 32'd7, cyc, bcnt, hi, lo, dz);
      @(negedge clk);
      vec_cnt++; if (lo !== 32'd14) begin err_cnt++; $display("FAIL divu_quo got %0d want 14", lo); end
      vec_cnt++; if (hi !== 32'd2) begin err_cnt++; $display("FAIL divu_rem got %0d want 2", hi); end
      vec_cnt++; if (dz !== 1'b0) begin err_cnt++; $display("FAIL dz_clear got %b want 0", dz); end
   endtask

   task automatic test_ignore_start;
      int cyc, bcnt; logic [31:0] hi, lo;
      cyc = 0; bcnt = 0; hi = 'x; lo = 'x;
      bus.i_op = OP_DIVU; bus.i_a = 32'd1000; bus.i_b = 32'd3; bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         if (bus.o_busy) bcnt++;
         if (bus.o_done) begin cyc = n; hi = bus.o_hi; lo = bus.o_lo; break; end
         bus.i_start = (n == 10);
         if (n == 10) begin bus.i_op = OP_MULTU; bus.i_a = 32'd5; bus.i_b = 32'd5; end
         bus.i_lo_we = (n == 15);
         bus.i_wdata = 32'hAAAA_5555;
         @(negedge clk);
      end
      bus.i_start = 1'b0; bus.i_lo_we = 1'b0;
      vec_cnt++; if (cyc !== 33) begin err_cnt++; $display("FAIL ign_latency got %0d want 33", cyc); end
      vec_cnt++; if (bcnt !== 32) begin err_cnt++; $display("FAIL ign_busy got %0d want 32", bcnt); end
      vec_cnt++; if (lo !== 32'd333) begin err_cnt++; $display("FAIL ign_lo got %0d want 333", lo); end
      vec_cnt++; if (hi !== 32'd1) begin err_cnt++; $display("FAIL ign_hi got %0d want 1", hi); end
      @(negedge clk);
      vec_cnt++; if (bus.o_lo !== 32'd333) begin err_cnt++; $display("FAIL ign_lo_hold got %0d want 333", bus.o_lo); end
   endtask

   task automatic test_reset_mid;
      int done_seen, busy_seen;
      done_seen = 0; busy_seen = 0;
      bus.i_op = OP_MULTU; bus.i_a = 32'd5; bus.i_b = 32'd6; bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      repeat (11) @(negedge clk);
      rst_n = 1'b0;
      #1;
      vec_cnt++; if (bus.o_busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_busy got %b want 0", bus.o_busy); end
      vec_cnt++; if (bus.o_hi !== 32'h0) begin err_cnt++; $display("FAIL rmid_hi got %h want 0", bus.o_hi); end
      vec_cnt++; if (bus.o_lo !== 32'h0) begin err_cnt++; $display("FAIL rmid_lo got %h want 0", bus.o_lo); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.o_done) done_seen++;
         if (bus.o_busy) busy_seen++;
      end
      vec_cnt++; if (done_seen !== 0) begin err_cnt++; $display("FAIL rmid_done got %0d want 0", done_seen); end
      vec_cnt++; if (busy_seen !== 0) begin err_cnt++; $display("FAIL rmid_busy_after got %0d want 0", busy_seen); end
      vec_cnt++; if (bus.o_lo !== 32'h0) begin err_cnt++; $display("FAIL rmid_lo_after got %h want 0", bus.o_lo); end
   endtask

   task automatic test_mthi_mtlo;
      logic [31:0] hi, lo;
      hi = 'x; lo = 'x;
      bus.i_hi_we = 1'b1; bus.i_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.i_hi_we = 1'b0; bus.i_lo_we = 1'b1; bus.i_wdata = 32'h1234_5678;
      vec_cnt++; if (bus.o_hi !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL mthi got %h want deadbeef", bus.o_hi); end
      @(negedge clk);
      vec_cnt++; if (bus.o_lo !== 32'h1234_5678) begin err_cnt++; $display("FAIL mtlo got %h want 12345678", bus.o_lo); end
      vec_cnt++; if (bus.o_hi !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL mtlo_hi_keep got %h want deadbeef", bus.o_hi); end
      bus.i_wdata = 32'h0000_0055; bus.i_op = OP_MULTU; bus.i_a = 32'd3; bus.i_b = 32'd4; bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0; bus.i_lo_we = 1'b0;
      vec_cnt++; if (bus.o_lo !== 32'h1234_5678) begin err_cnt++; $display("FAIL start_wins_lo got %h want 12345678", bus.o_lo); end
      for (int n = 0; n < 100; n++) begin
         if (bus.o_done) begin hi = bus.o_hi; lo = bus.o_lo; break; end
         @(negedge clk);
      end
      vec_cnt++; if (lo !== 32'd12) begin err_cnt++; $display("FAIL start_wins_res got %h want 0000000c", lo); end
      vec_cnt++; if (hi !== 32'd0) begin err_cnt++; $display("FAIL start_wins_hi got %h want 0", hi); end
      @(negedge clk);
      bus.i_hi_we = 1'b1; bus.i_lo_we = 1'b1; bus.i_wdata = 32'h0BAD_F00D;
      @(negedge clk);
      bus.i_hi_we = 1'b0; bus.i_lo_we = 1'b0;
      vec_cnt++; if (bus.o_hi !== 32'h0BAD_F00D) begin err_cnt++; $display("FAIL both_we_hi got %h want 0badf00d", bus.o_hi); end
      vec_cnt++; if (bus.o_lo !== 32'h0BAD_F00D) begin err_cnt++; $display("FAIL both_we_lo got %h want 0badf00d", bus.o_lo); end
   endtask

   task automatic test_back_to_back;
      int cyc, bcnt; logic [31:0] hi, lo; logic dz;
      do_op(OP_MULTU, 32'd2, 32'd3, cyc, bcnt, hi, lo, dz);
      bus.i_op = OP_DIVU; bus.i_a = 32'd1000; bus.i_b = 32'd3; bus.i_start = 1'b1;
      @(negedge clk);
      vec_cnt++; if (bus.o_busy !== 1'b0) begin err_cnt++; $display("FAIL b2b_fin_start got %b want 0", bus.o_busy); end
      vec_cnt++; if (bus.o_lo !== 32'd6) begin err_cnt++; $display("FAIL b2b_first_lo got %0d want 6", bus.o_lo); end
      do_op(OP_DIVU, 32'd1000, 32'd3, cyc, bcnt, hi, lo, dz);
      vec_cnt++; if (cyc !== 33) begin err_cnt++; $display("FAIL b2b_latency got %0d want 33", cyc); end
      vec_cnt++; if (lo !== 32'd333) begin err_cnt++; $display("FAIL b2b_lo got %0d want 333", lo); end
      @(negedge clk);
   endtask

   initial begin
      bus.i_start = 1'b0; bus.i_op = 2'b00; bus.i_a = '0; bus.i_b = '0;
      bus.i_hi_we = 1'b0; bus.i_lo_we = 1'b0; bus.i_wdata = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_multu();
      test_signed();
      test_div_zero();
      test_ignore_start();
      test_reset_mid();
      test_mthi_mtlo();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
